// File: rtl/store_monitor.sv
// store_monitor: passive pass/fail/timeout checker on the MIPS data-memory store bus.
// Define STORE_MONITOR_LOG_EN to build the store-log FIFO; otherwise the log ports read as 0.
module store_monitor #(
  parameter logic [31:0] PASS_ADDR  = 32'd84,
  parameter logic [31:0] PASS_DATA  = 32'd7,
  parameter logic [31:0] ALLOW_ADDR = 32'd80,
  parameter int          TIMEOUT    = 1000,
  parameter int          LOG_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [15:0] wr_count,
  input  logic        log_rd,
  output logic        log_valid,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  state_t        state_r;
  logic [TW-1:0] tcnt_r;
  logic          done_r, pass_r, fail_r, timeout_r;
  logic [15:0]   wr_r;
  logic          store_s, hit_pass_s, hit_fail_s;

  // Classify the store on the bus; unknown strobe or compare bits fall through to FAIL.
  always_comb begin
    store_s    = 1'b0;
    hit_pass_s = 1'b0;
    hit_fail_s = 1'b0;
    if (state_r == ST_RUN) begin
      if (memwrite == 1'b0) begin
        store_s = 1'b0;
      end else if (memwrite == 1'b1) begin
        store_s = 1'b1;
        if ((dataadr == PASS_ADDR) && (writedata == PASS_DATA)) begin
          hit_pass_s = 1'b1;
        end else if (dataadr == PASS_ADDR) begin
          hit_fail_s = 1'b1;
        end else if (dataadr == ALLOW_ADDR) begin
          hit_fail_s = 1'b0;
        end else begin
          hit_fail_s = 1'b1;
        end
      end else begin
        hit_fail_s = 1'b1;
      end
    end else begin
      store_s = 1'b0;
    end
  end

  // Verdict FSM with registered flags; a verdict store beats the timeout on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_RESET;
      tcnt_r    <= {TW{1'b0}};
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      fail_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else if (clear) begin
      state_r   <= ST_RUN;
      tcnt_r    <= {TW{1'b0}};
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      fail_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RESET: begin
          state_r <= ST_RUN;
          tcnt_r  <= {TW{1'b0}};
        end
        ST_RUN: begin
          if (hit_pass_s) begin
            state_r <= ST_PASS;
            done_r  <= 1'b1;
            pass_r  <= 1'b1;
          end else if (hit_fail_s) begin
            state_r <= ST_FAIL;
            done_r  <= 1'b1;
            fail_r  <= 1'b1;
          end else if (tcnt_r == TLAST) begin
            state_r   <= ST_TIMEOUT;
            done_r    <= 1'b1;
            timeout_r <= 1'b1;
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
          end
        end
        ST_PASS, ST_FAIL, ST_TIMEOUT: begin
          state_r <= state_r;
        end
        default: begin
          state_r   <= ST_RESET;
          done_r    <= 1'b0;
          pass_r    <= 1'b0;
          fail_r    <= 1'b0;
          timeout_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of stores accepted in RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_r <= 16'd0;
    end else if (clear) begin
      wr_r <= 16'd0;
    end else if (store_s && (wr_r != 16'hFFFF)) begin
      wr_r <= wr_r + 16'd1;
    end else begin
      wr_r <= wr_r;
    end
  end

  assign done     = done_r;
  assign pass     = pass_r;
  assign fail     = fail_r;
  assign timeout  = timeout_r;
  assign wr_count = wr_r;

`ifdef STORE_MONITOR_LOG_EN
  localparam int AW = $clog2(LOG_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(LOG_DEPTH);

  logic [63:0]   mem_r [LOG_DEPTH];
  logic [AW-1:0] wptr_r, rptr_r;
  logic [AW:0]   cnt_r;
  logic          ovf_r, full_s, pop_s, push_s;

  assign full_s = (cnt_r == DEPTH_C);
  assign pop_s  = log_rd && (cnt_r != {(AW + 1){1'b0}});
  assign push_s = store_s && (!full_s || pop_s);

  // Log storage written at the tail; contents need no reset since pointers qualify them.
  always_ff @(posedge clk) begin
    if (push_s && !clear) begin
      mem_r[wptr_r] <= {dataadr, writedata};
    end
  end

  // Log pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_r <= {AW{1'b0}};
      rptr_r <= {AW{1'b0}};
      cnt_r  <= {(AW + 1){1'b0}};
      ovf_r  <= 1'b0;
    end else if (clear) begin
      wptr_r <= {AW{1'b0}};
      rptr_r <= {AW{1'b0}};
      cnt_r  <= {(AW + 1){1'b0}};
      ovf_r  <= 1'b0;
    end else begin
      if (push_s) wptr_r <= wptr_r + AW'(1);
      if (pop_s)  rptr_r <= rptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + (AW + 1)'(1);
        2'b01:   cnt_r <= cnt_r - (AW + 1)'(1);
        default: cnt_r <= cnt_r;
      endcase
      if (store_s && full_s && !pop_s) ovf_r <= 1'b1;
    end
  end

  assign log_valid    = (cnt_r != {(AW + 1){1'b0}});
  assign log_addr     = log_valid ? mem_r[rptr_r][63:32] : 32'd0;
  assign log_data     = log_valid ? mem_r[rptr_r][31:0]  : 32'd0;
  assign log_overflow = ovf_r;
`else
  logic unused_s;
  assign unused_s     = log_rd ^ (LOG_DEPTH < 32'sd2);
  assign log_valid    = 1'b0;
  assign log_addr     = 32'd0;
  assign log_data     = 32'd0;
  assign log_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_store_monitor.sv
// Bench for store_monitor: vector table, hand sequences for timeout/log/reset corners,
// and randomized stores checked against a queue-based reference model.
module tb_store_monitor;
  localparam int TO = 10;
  localparam int LD = 8;

  logic        clk = 1'b0;
  logic        reset, clear, memwrite, log_rd;
  logic [31:0] dataadr, writedata;
  logic        done, pass, fail, timeout, log_valid, log_overflow;
  logic [15:0] wr_count;
  logic [31:0] log_addr, log_data;

  int n_tests = 0;
  int n_fail  = 0;

  store_monitor #(
    .PASS_ADDR(32'd84), .PASS_DATA(32'd7), .ALLOW_ADDR(32'd80),
    .TIMEOUT(TO), .LOG_DEPTH(LD)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .wr_count(wr_count), .log_rd(log_rd), .log_valid(log_valid),
    .log_addr(log_addr), .log_data(log_data), .log_overflow(log_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: verdict 0 none, 1 pass, 2 fail, 3 timeout.
  int          m_verdict;
  bit          m_started;
  int          m_cycles;
  int          m_wr;
  logic [63:0] m_log[$];
  bit          m_ovf;

  typedef struct {
    bit          mw;
    logic [31:0] a;
    logic [31:0] d;
    bit          clr;
    logic [3:0]  exp;   // {done, pass, fail, timeout}
    logic [15:0] wr;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_verdict = 0; m_started = 0; m_cycles = 0; m_wr = 0; m_ovf = 0;
    m_log.delete();
  endtask

  task automatic model_edge(input bit mw, input logic [31:0] a, input logic [31:0] d,
                            input bit clr, input bit rd);
    if (clr) begin
      m_started = 1; m_verdict = 0; m_cycles = 0; m_wr = 0; m_ovf = 0;
      m_log.delete();
    end else if (!m_started) begin
      m_started = 1;
    end else begin
      if (rd && (m_log.size() != 0)) void'(m_log.pop_front());
      if (m_verdict == 0) begin
        m_cycles++;
        if (mw) begin
          if (m_wr < 65535) m_wr++;
          if (m_log.size() < LD) m_log.push_back({a, d});
          else m_ovf = 1;
          if (a == 32'd84) m_verdict = (d == 32'd7) ? 1 : 2;
          else if (a != 32'd80) m_verdict = 2;
        end
        if ((m_verdict == 0) && (m_cycles == TO)) m_verdict = 3;
      end
    end
  endtask

  task automatic drive(input bit mw, input logic [31:0] a, input logic [31:0] d,
                       input bit clr, input bit rd);
    memwrite = mw; dataadr = a; writedata = d; clear = clr; log_rd = rd;
  endtask

  task automatic tick();
    model_edge(memwrite, dataadr, writedata, clear, log_rd);
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string tag);
`ifdef STORE_MONITOR_LOG_EN
    check({tag, ".log_valid"}, 64'(log_valid), 64'(m_log.size() != 0));
    check({tag, ".log_overflow"}, 64'(log_overflow), 64'(m_ovf));
    if (m_log.size() != 0) begin
      check({tag, ".log_addr"}, 64'(log_addr), 64'(m_log[0][63:32]));
      check({tag, ".log_data"}, 64'(log_data), 64'(m_log[0][31:0]));
    end
`else
    check({tag, ".log_valid"}, 64'(log_valid), 64'(0));
    check({tag, ".log_overflow"}, 64'(log_overflow), 64'(0));
    check({tag, ".log_addr"}, 64'(log_addr), 64'(0));
    check({tag, ".log_data"}, 64'(log_data), 64'(0));
`endif
  endtask

  task automatic check_model(input string tag);
    check({tag, ".done"}, 64'(done), 64'(m_verdict != 0));
    check({tag, ".pass"}, 64'(pass), 64'(m_verdict == 1));
    check({tag, ".fail"}, 64'(fail), 64'(m_verdict == 2));
    check({tag, ".timeout"}, 64'(timeout), 64'(m_verdict == 3));
    check({tag, ".wr_count"}, 64'(wr_count), 64'(m_wr));
    check_log(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".flags"}, 64'({done, pass, fail, timeout}), 64'(0));
    check({tag, ".wr_count"}, 64'(wr_count), 64'(0));
    check({tag, ".log"}, 64'({log_valid, log_overflow}), 64'(0));
    check({tag, ".log_addr"}, 64'(log_addr), 64'(0));
    check({tag, ".log_data"}, 64'(log_data), 64'(0));
  endtask

  task automatic apply_reset(input bit store_on_release);
    reset = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    check_zero("rst");
    if (store_on_release) drive(1'b1, 32'd88, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check_model("rel");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bit mw, clr, rd;
    logic [31:0] a, d;
    int r;

    vecs[0]  = '{1'b1, 32'd80, 32'd3, 1'b0, 4'b0000, 16'd1};
    vecs[1]  = '{1'b1, 32'd84, 32'd7, 1'b0, 4'b1100, 16'd2};
    vecs[2]  = '{1'b1, 32'd84, 32'd6, 1'b0, 4'b1100, 16'd2};
    vecs[3]  = '{1'b1, 32'd84, 32'd6, 1'b1, 4'b0000, 16'd0};
    vecs[4]  = '{1'b1, 32'd84, 32'd6, 1'b0, 4'b1010, 16'd1};
    vecs[5]  = '{1'b1, 32'd84, 32'd7, 1'b0, 4'b1010, 16'd1};
    vecs[6]  = '{1'b0, 32'd0,  32'd0, 1'b1, 4'b0000, 16'd0};
    vecs[7]  = '{1'b1, 32'd88, 32'd7, 1'b0, 4'b1010, 16'd1};
    vecs[8]  = '{1'b0, 32'd0,  32'd0, 1'b1, 4'b0000, 16'd0};
    vecs[9]  = '{1'b1, 32'd84, 32'd7, 1'b0, 4'b1100, 16'd1};
    vecs[10] = '{1'b1, 32'd80, 32'd5, 1'b0, 4'b1100, 16'd1};
    vecs[11] = '{1'b0, 32'd0,  32'd0, 1'b1, 4'b0000, 16'd0};
    vecs[12] = '{1'b1, 32'd80, 32'd1, 1'b0, 4'b0000, 16'd1};
    vecs[13] = '{1'b1, 32'd80, 32'd2, 1'b0, 4'b0000, 16'd2};

    reset = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #3;
    check_zero("por");

    apply_reset(1'b0);
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].mw, vecs[i].a, vecs[i].d, vecs[i].clr, 1'b0);
      tick();
      check($sformatf("vec%0d.flags", i), 64'({done, pass, fail, timeout}), 64'(vecs[i].exp));
      check($sformatf("vec%0d.wr_count", i), 64'(wr_count), 64'(vecs[i].wr));
      check_log($sformatf("vec%0d", i));
    end

    // Timeout after TO idle cycles; a store on the release edge is ignored.
    apply_reset(1'b1);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      check_model("to_idle");
    end
    check("to.before", 64'(done), 64'(0));
    tick();
    check("to.hit", 64'({done, timeout}), 64'(2'b11));
    check_model("to_hit");

    // Verdict store on the timeout edge wins.
    apply_reset(1'b0);
    for (int i = 0; i < TO - 1; i++) tick();
    drive(1'b1, 32'd84, 32'd7, 1'b0, 1'b0);
    tick();
    check("to.pass_wins", 64'({done, pass, fail, timeout}), 64'(4'b1100));
    check_model("to_pass");

    // Allowed stores do not hold off the timeout but are still counted.
    apply_reset(1'b0);
    for (int i = 0; i < TO; i++) begin
      drive(1'b1, 32'd80, 32'(i), 1'b0, 1'b0);
      tick();
    end
    check("to.allow", 64'({timeout, wr_count}), 64'({1'b1, 16'(TO)}));
    check_model("to_allow");

`ifdef STORE_MONITOR_LOG_EN
    // Nine stores into an eight-entry log: overflow, then ordered drain.
    apply_reset(1'b0);
    for (int i = 1; i <= LD + 1; i++) begin
      drive(1'b1, 32'd80, 32'(i), 1'b0, 1'b0);
      tick();
    end
    check("ovf.set", 64'(log_overflow), 64'(1));
    for (int k = 1; k <= LD; k++) begin
      check("ovf.order", 64'(log_data), 64'(k));
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      tick();
      check_model("ovf_pop");
    end
    check("ovf.empty", 64'(log_valid), 64'(0));
    tick();
    check_model("ovf_rd_empty");

    // Full log with simultaneous store and pop: occupancy holds, no overflow.
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < LD; i++) begin
      drive(1'b1, 32'd80, 32'(11 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'd80, 32'd19, 1'b0, 1'b1);
    tick();
    check("full.pushpop_ovf", 64'(log_overflow), 64'(0));
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int k = 0; k < LD; k++) begin
      check("full.order", 64'({log_valid, log_data}), 64'({1'b1, 32'(12 + k)}));
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      tick();
    end
    check("full.drained", 64'(log_valid), 64'(0));
    check_model("full_end");
`endif

    // Asynchronous reset mid-run, then a clean restart.
    apply_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd80, 32'(i), 1'b0, 1'b0);
      tick();
    end
    check("mid.wr", 64'(wr_count), 64'(3));
    #2;
    reset = 1'b0;
    #1;
    check_zero("mid_async");
    model_reset();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check_model("mid_rel");
    drive(1'b1, 32'd84, 32'd7, 1'b0, 1'b0);
    tick();
    check("mid.restart", 64'({pass, wr_count}), 64'({1'b1, 16'd1}));

    // Randomized stores against the model.
    apply_reset(1'b0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(199) == 0) apply_reset(1'($urandom_range(1)));
      r   = int'($urandom_range(99));
      mw  = ($urandom_range(1) == 1);
      if (r < 85)      a = 32'd80;
      else if (r < 93) a = 32'd84;
      else             a = $urandom;
      d   = ($urandom_range(3) == 0) ? $urandom : 32'd7;
      clr = ($urandom_range(15) == 0);
      rd  = ($urandom_range(i[8] ? 1 : 7) == 0);
      drive(mw, a, d, clr, rd);
      tick();
      check_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
